// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller
// Multicycle ARM control unit. A single FSM runs each instruction over several
// cycles. It drives every datapath select and write enable, and it holds the
// NZCV flag register.
// Optional feature macro: ARM_MULDIV_EN. When it is defined, the MUL/MLA/UDIV/SDIV
// path is present: the MDSTART/MDWAIT/MDWB states and the latency down-counter.
// When it is undefined, those encodings retire as 2-cycle NOPs and MulDivStart,
// MulDivOp are tied to 0.
module arm_multicycle_controller #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        MulDivStart,
  output logic [1:0]  MulDivOp
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    MDSTART = 4'd10,
    MDWAIT  = 4'd11,
    MDWB    = 4'd12
  } state_t;

  state_t state, next_state;

  logic [3:0] cond;
  logic [1:0] op;
  logic [3:0] cmd;
  logic       s_bit;
  logic       imm_bit;
  logic       is_load;
  logic       md_pattern;
  logic       is_muldiv;
  logic       dp_defined;
  logic       is_cmp;
  logic       is_arith;
  logic [1:0] alu_op;
  logic       cond_pass;
  logic [3:0] flags;

  logic pc_write_en;
  logic ir_write_en;
  logic reg_write_en;
  logic mem_write_en;
  logic md_start;

  assign cond    = Instr[31:28];
  assign op      = Instr[27:26];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign imm_bit = Instr[25];
  assign is_load = Instr[20];

  // Multiply/divide lives inside the Op=00 space: register form, 1001 in bits 7:4,
  // and bits 24:23 equal to 00 (MUL/MLA) or 01 (divide).
  assign md_pattern = (op == 2'b00) && !imm_bit && (Instr[7:4] == 4'b1001);
  assign is_muldiv  = md_pattern && !Instr[24];

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  // Fields this controller does not look at are register numbers and immediates.
  logic unused_bits;
  assign unused_bits = ^{Instr[19:8], Instr[3:0]};

  // Map the data-processing command to an ALU operation and note which commands exist.
  always_comb begin
    dp_defined = 1'b1;
    is_cmp     = 1'b0;
    is_arith   = 1'b0;
    alu_op     = 2'b00;
    case (cmd)
      4'b0100: begin alu_op = 2'b00; is_arith = 1'b1; end
      4'b0010: begin alu_op = 2'b01; is_arith = 1'b1; end
      4'b1010: begin alu_op = 2'b01; is_arith = 1'b1; is_cmp = 1'b1; end
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      default: dp_defined = 1'b0;
    endcase
  end

  // Evaluate the condition field against the stored NZCV flags.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flags[2];
      4'b0001: cond_pass = !flags[2];
      4'b0010: cond_pass = flags[1];
      4'b0011: cond_pass = !flags[1];
      4'b0100: cond_pass = flags[3];
      4'b0101: cond_pass = !flags[3];
      4'b0110: cond_pass = flags[0];
      4'b0111: cond_pass = !flags[0];
      4'b1000: cond_pass = flags[1] && !flags[2];
      4'b1001: cond_pass = !flags[1] || flags[2];
      4'b1010: cond_pass = (flags[3] == flags[0]);
      4'b1011: cond_pass = (flags[3] != flags[0]);
      4'b1100: cond_pass = !flags[2] && (flags[3] == flags[0]);
      4'b1101: cond_pass = flags[2] || (flags[3] != flags[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // The flags capture the ALU result at the end of an execute cycle when S is set.
  // Logical operations keep the previous C and V.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if ((state == EXECR || state == EXECI) && s_bit) begin
      if (is_arith) begin
        flags <= ALUFlags;
      end else begin
        flags[3:2] <= ALUFlags[3:2];
      end
    end
  end

`ifdef ARM_MULDIV_EN
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       md_op;
  logic [CNT_W-1:0] cnt;

  assign md_op       = Instr[23] ? {1'b1, Instr[22]} : {1'b0, Instr[21]};
  assign MulDivOp    = is_muldiv ? md_op : 2'b00;
  assign MulDivStart = md_start && !reset;

  // The latency counter is loaded with the unit latency minus one at the start
  // pulse and then counts down while the FSM waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == MDSTART) begin
      cnt <= md_op[1] ? DIV_LOAD : MUL_LOAD;
    end else if (state == MDWAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end
`else
  logic unused_params;
  assign unused_params = (MUL_CYCLES >= 1) & (DIV_CYCLES >= 1) & (CNT_W >= 1) & md_start;
  assign MulDivOp      = 2'b00;
  assign MulDivStart   = 1'b0;
`endif

  // State register. Reset returns to FETCH even in the middle of a multicycle operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state sequencing for every instruction class.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (!cond_pass) begin
          next_state = FETCH;
        end else begin
          case (op)
            2'b01: next_state = MEMADR;
            2'b10: next_state = BRANCH;
            2'b00: begin
              if (is_muldiv) begin
`ifdef ARM_MULDIV_EN
                next_state = MDSTART;
`else
                next_state = FETCH;
`endif
              end else if (dp_defined) begin
                next_state = imm_bit ? EXECI : EXECR;
              end else begin
                next_state = FETCH;
              end
            end
            default: next_state = FETCH;
          endcase
        end
      end
      MEMADR: next_state = is_load ? MEMRD : MEMWR;
      MEMRD:  next_state = MEMWB;
      MEMWB:  next_state = FETCH;
      MEMWR:  next_state = FETCH;
      EXECR:  next_state = ALUWB;
      EXECI:  next_state = ALUWB;
      ALUWB:  next_state = FETCH;
      BRANCH: next_state = FETCH;
`ifdef ARM_MULDIV_EN
      MDSTART: next_state = MDWAIT;
      // The wait ends on the cycle in which the counter steps to zero. MDWB
      // then falls exactly the unit latency after the start pulse.
      MDWAIT:  next_state = (cnt > CNT_W'(1)) ? MDWAIT : MDWB;
      MDWB:    next_state = FETCH;
`endif
      default: next_state = FETCH;
    endcase
  end

  // Per-state datapath controls. Write enables are raised only where needed.
  always_comb begin
    pc_write_en  = 1'b0;
    ir_write_en  = 1'b0;
    reg_write_en = 1'b0;
    mem_write_en = 1'b0;
    md_start     = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUControl   = 2'b00;
    case (state)
      FETCH: begin
        ir_write_en = 1'b1;
        pc_write_en = 1'b1;
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc       = 1'b1;
        mem_write_en = 1'b1;
      end
      MEMWB: begin
        reg_write_en = 1'b1;
        ResultSrc    = 2'b01;
      end
      EXECR: ALUControl = alu_op;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      ALUWB: reg_write_en = !is_cmp;
      BRANCH: begin
        ALUSrcB     = 2'b01;
        ResultSrc   = 2'b10;
        pc_write_en = 1'b1;
      end
`ifdef ARM_MULDIV_EN
      MDSTART: md_start = 1'b1;
      MDWB: begin
        reg_write_en = 1'b1;
        ResultSrc    = 2'b11;
      end
`endif
      default: ;
    endcase
  end

  assign PCWrite  = pc_write_en && !reset;
  assign IRWrite  = ir_write_en && !reset;
  assign RegWrite = reg_write_en && !reset;
  assign MemWrite = mem_write_en && !reset;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb_arm_multicycle_controller
// Directed and random instruction stream. The bench checks it against an
// instruction-level model that gives, for each instruction, the cycle-by-cycle
// list of write enables and the key select values.
module tb_arm_multicycle_controller;

  localparam int MUL_L = 2;
  localparam int DIV_L = 32;

  localparam int K_NOP = 0;
  localparam int K_DP  = 1;
  localparam int K_LDR = 2;
  localparam int K_STR = 3;
  localparam int K_B   = 4;
  localparam int K_MD  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, MulDivOp;
  logic        ALUSrcA, MulDivStart;

  int total = 0;
  int bad   = 0;
  logic [3:0] mflags = 4'b0000;

  arm_multicycle_controller #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .MulDivStart(MulDivStart), .MulDivOp(MulDivOp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy & !z;
      4'd9:  return !cy | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int classify(input logic [31:0] i);
    if (i[27:26] == 2'b01) return i[20] ? K_LDR : K_STR;
    if (i[27:26] == 2'b10) return K_B;
    if (i[27:26] == 2'b11) return K_NOP;
    if (!i[25] && i[7:4] == 4'b1001 && (i[24:23] == 2'b00 || i[24:23] == 2'b01)) begin
`ifdef ARM_MULDIV_EN
      return K_MD;
`else
      return K_NOP;
`endif
    end
    case (i[24:21])
      4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010: return K_DP;
      default: return K_NOP;
    endcase
  endfunction

  function automatic logic [1:0] aluCode(input logic [3:0] c);
    case (c)
      4'b0100: return 2'd0;
      4'b0010, 4'b1010: return 2'd1;
      4'b0000: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Runs one whole instruction starting from FETCH and checks every cycle.
  task automatic applyStimulus(input logic [31:0] ins, input logic [3:0] af, input string name);
    int k;
    int lat;
    logic [1:0] mdop;
    logic [4:0] en[$];
    k = classify(ins);
    if (!condHolds(ins[31:28], mflags)) k = K_NOP;
    lat  = ins[23] ? DIV_L : MUL_L;
    mdop = ins[23] ? {1'b1, ins[22]} : {1'b0, ins[21]};
    en.push_back(5'b11000);
    en.push_back(5'b00000);
    case (k)
      K_DP:  begin en.push_back(5'b00000); en.push_back({2'b00, ins[24:21] != 4'b1010, 2'b00}); end
      K_LDR: begin en.push_back(5'b00000); en.push_back(5'b00000); en.push_back(5'b00100); end
      K_STR: begin en.push_back(5'b00000); en.push_back(5'b00010); end
      K_B:   en.push_back(5'b10000);
      K_MD: begin
        en.push_back(5'b00001);
        for (int w = 1; w < lat; w++) en.push_back(5'b00000);
        en.push_back(5'b00100);
      end
      default: ;
    endcase
    Instr = ins;
    ALUFlags = af;
    #1;
    for (int c = 0; c < en.size(); c++) begin
      checkOutput($sformatf("%s c%0d enables", name, c),
                  8'({PCWrite, IRWrite, RegWrite, MemWrite, MulDivStart}), 8'(en[c]));
      if (c == 0) begin
        checkOutput($sformatf("%s fetch sel", name),
                    8'({AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'h62);
      end
      if (c == 1) begin
        checkOutput($sformatf("%s decode sel", name),
                    8'({ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'h62);
        checkOutput($sformatf("%s immsrc", name), 8'(ImmSrc), 8'(ins[27:26]));
`ifndef ARM_MULDIV_EN
        checkOutput($sformatf("%s muldivop", name), 8'(MulDivOp), 8'h00);
`endif
      end
      if (k == K_DP && c == 2)
        checkOutput($sformatf("%s exec sel", name), 8'({ALUSrcA, ALUSrcB, ALUControl}),
                    8'({1'b0, ins[25] ? 2'b01 : 2'b00, aluCode(ins[24:21])}));
      if (k == K_DP && c == 3)
        checkOutput($sformatf("%s aluwb src", name), 8'(ResultSrc), 8'h00);
      if (k == K_LDR && c == 2)
        checkOutput($sformatf("%s memadr sel", name), 8'({ALUSrcB, ALUControl}), 8'h04);
      if (k == K_LDR && c == 3)
        checkOutput($sformatf("%s memrd adr", name), 8'(AdrSrc), 8'h01);
      if (k == K_LDR && c == 4)
        checkOutput($sformatf("%s memwb src", name), 8'(ResultSrc), 8'h01);
      if (k == K_STR && c == 3)
        checkOutput($sformatf("%s memwr adr", name), 8'(AdrSrc), 8'h01);
      if (k == K_B && c == 2)
        checkOutput($sformatf("%s branch sel", name),
                    8'({ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'h12);
      if (k == K_MD && c == 2)
        checkOutput($sformatf("%s start op", name), 8'(MulDivOp), 8'(mdop));
      if (k == K_MD && c == en.size() - 1)
        checkOutput($sformatf("%s mdwb sel", name), 8'({ResultSrc, MulDivOp}), 8'({2'b11, mdop}));
      @(negedge clk);
      #1;
    end
    if (k == K_DP && ins[20]) begin
      if (ins[24:21] == 4'b0000 || ins[24:21] == 4'b1100) mflags[3:2] = af[3:2];
      else mflags = af;
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) r[31:28] = 4'b1110;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: begin
        r[27:26] = 2'b00;
        case ($urandom_range(0, 6))
          0: r[24:21] = 4'b0100;
          1: r[24:21] = 4'b0010;
          2: r[24:21] = 4'b0000;
          3: r[24:21] = 4'b1100;
          4: r[24:21] = 4'b1010;
          5: r[24:21] = 4'b0001;
          default: r[24:21] = 4'b1111;
        endcase
        if (!r[25]) r[4] = 1'b0;
      end
      4, 5: r[27:26] = 2'b01;
      6:    r[27:26] = 2'b10;
      7:    r[27:26] = 2'b11;
      8: begin r[27:23] = 5'b00000; r[7:4] = 4'b1001; end
      default: begin r[27:23] = 5'b00001; r[7:4] = 4'b1001; end
    endcase
    return r;
  endfunction

  initial begin
    int mid_steps;
    logic [31:0] mid_ins;
    reset = 1'b1;
    Instr = 32'h0;
    ALUFlags = 4'h0;
    #2;
    checkOutput("reset enables", 8'({PCWrite, IRWrite, RegWrite, MemWrite, MulDivStart}), 8'h00);
    checkOutput("reset sel", 8'({AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'h62);
    @(negedge clk);
    reset = 1'b0;
    #1;

    applyStimulus(32'hE0821003, 4'h0, "ADD");
    applyStimulus(32'hE5921004, 4'h0, "LDR");
    applyStimulus(32'hE5821004, 4'h0, "STR");
    applyStimulus(32'hE0521003, 4'b0100, "SUBS_Z");
    applyStimulus(32'h00821003, 4'h0, "ADDEQ_pass");
    applyStimulus(32'hE0521003, 4'b0000, "SUBS_nz");
    applyStimulus(32'h00821003, 4'h0, "ADDEQ_fail");
    applyStimulus(32'hEA000001, 4'h0, "B");
    applyStimulus(32'hE0214392, 4'h0, "MLA");
    applyStimulus(32'hE0C10392, 4'h0, "SDIV");
    applyStimulus(32'hE0521003, 4'b0100, "SUBS_Z2");

`ifdef ARM_MULDIV_EN
    mid_ins = 32'hE0C10392;
    mid_steps = 12;
`else
    mid_ins = 32'hE5921004;
    mid_steps = 3;
`endif
    Instr = mid_ins;
    #1;
    repeat (mid_steps) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset enables", 8'({PCWrite, IRWrite, RegWrite, MemWrite, MulDivStart}), 8'h00);
    checkOutput("midreset sel", 8'({AdrSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 8'h62);
    @(negedge clk);
    reset = 1'b0;
    mflags = 4'b0000;
    #1;
    applyStimulus(32'h00821003, 4'h0, "ADDEQ_after_reset");
    applyStimulus(32'h10821003, 4'h0, "ADDNE_after_reset");

    for (int n = 0; n < 80; n++) begin
      applyStimulus(randInstr(), 4'($urandom_range(0, 15)), $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
